// File: rtl/even_parity_serializer_pkg.sv
// rtl/even_parity_serializer_pkg.sv - shared types and constants for the even-parity serializer
package even_parity_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bit-counter width for a frame of w data bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/even_parity_serializer_piso_shift_reg.sv
// rtl/even_parity_serializer_piso_shift_reg.sv - parallel-in serial-out shift register with bit counter
module piso_shift_reg
    import even_parity_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             next_bit,
    output logic             at_last
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    // Load captures a fresh word with the counter at bit 0; shift advances one bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= din;
            cnt <= '0;
        end else if (shift) begin
            sh  <= sh >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    // sh[0] is the bit on the wire now, so sh[1] is the one to present next.
    assign next_bit = sh[1];
    assign at_last  = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/even_parity_serializer.sv
// rtl/even_parity_serializer.sv - LSB-first serializer appending an even-parity bit per frame
module even_parity_serializer
    import even_parity_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last
);

    state_t state;
    logic   parity_q;
    logic   accept;
    logic   shift_en;
    logic   next_bit;
    logic   at_last;

    // A new word may enter while idle or while the previous frame's parity bit is out.
    assign din_ready = !rst && ((state == ST_IDLE) || (state == ST_PARITY));
    assign accept    = din_valid && din_ready;
    // Counter holds at the last data bit so it never wraps inside a frame.
    assign shift_en  = (state == ST_SHIFT) && !at_last;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (shift_en),
        .din      (din),
        .next_bit (next_bit),
        .at_last  (at_last)
    );

    // Frame FSM; outputs are registered with the value the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            parity_q   <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_PARITY: begin
                    if (accept) begin
                        state      <= ST_SHIFT;
                        parity_q   <= ^din;
                        dout       <= din[0];
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    dout_valid <= 1'b1;
                    if (at_last) begin
                        state     <= ST_PARITY;
                        dout      <= parity_q;
                        dout_last <= 1'b1;
                    end else begin
                        dout      <= next_bit;
                        dout_last <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/even_parity_serializer.md
EVEN_PARITY_SERIALIZER -- requirements
Module: even_parity_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, meaning number of data bits per frame (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  WIDTH  parallel data word to transmit.
REQ-005 din_valid  input  1  din holds a word to send.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 dout  output  1  serial bit stream, LSB first, followed by an even-parity bit.
REQ-008 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-009 dout_last  output  1  dout carries the parity bit (final bit of frame).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, PARITY.
REQ-011 din_ready SHALL be combinational: 1 when state is IDLE or PARITY and rst is 0; otherwise 0.
REQ-012 A word SHALL be accepted on a rising edge where din_valid and din_ready are both 1; din is captured into a WIDTH-bit shift register and the parity register is loaded with the XOR of all din bits.
REQ-013 On acceptance the state SHALL go to SHIFT with bit counter 0; dout SHALL present din[0] in the cycle after acceptance (latency 1 cycle).
REQ-014 In SHIFT, dout SHALL present bit[count] of the captured word, dout_valid 1, dout_last 0; count increments each cycle from 0 to WIDTH-1.
REQ-015 When count = WIDTH-1 in SHIFT, the next state SHALL be PARITY; the counter SHALL NOT wrap past WIDTH-1 within a frame.
REQ-016 In PARITY, dout SHALL equal the stored parity bit, dout_valid 1, dout_last 1 for exactly one cycle.
REQ-017 The parity bit SHALL make the count of 1s across the WIDTH data bits plus the parity bit even.
REQ-018 From PARITY: if a word is accepted that cycle, next state SHALL be SHIFT (back-to-back, no idle gap, WIDTH+1 cycles per frame); else next state SHALL be IDLE.
REQ-019 In IDLE, dout, dout_valid and dout_last SHALL be 0.
REQ-020 din_valid asserted while in SHIFT SHALL be ignored; din changes during SHIFT SHALL NOT affect the frame in flight.
REQ-021 dout, dout_valid and dout_last SHALL be driven from registers (no combinational path from din or din_valid).

Reset
REQ-022 While rst is 1 at a rising edge: state SHALL become IDLE; counter, shift register and parity register SHALL become 0; dout, dout_valid and dout_last SHALL be 0 in the following cycle.
REQ-023 rst asserted mid-frame SHALL abort the frame; no remaining data or parity bit SHALL be emitted, and din offered during the reset cycle SHALL NOT be accepted.
REQ-024 After rst deasserts, the first accepted word SHALL start a complete new frame per REQ-013.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, SHIFT, PARITY) and the default WIDTH constant.
REQ-026 The counter width SHALL be $clog2(WIDTH), taken from a package function or localparam.
REQ-027 The parallel-in serial-out shift register with its bit counter SHALL be one sub-module, piso_shift_reg; the FSM and parity logic stay in even_parity_serializer.

Verification
REQ-028 din=0xA5 accepted from IDLE -> dout over the next 9 cycles = 1,0,1,0,0,1,0,1 then 0; dout_last only on the 9th cycle.
REQ-029 din=0x07 -> data bits 1,1,1,0,0,0,0,0 then parity 1; din=0x00 -> eight 0s then parity 0.
REQ-030 Back-to-back: 0xFF then 0x01, din_valid held high -> 18 consecutive dout_valid cycles, bits 1x8, 0, 1, 0x7, 1; second word accepted in the PARITY cycle of the first.
REQ-031 rst asserted on the 4th data bit of 0xA5 -> dout_valid 0 from the next cycle; no parity bit; din_ready 0 during rst; next word 0x3C gives 0,0,1,1,1,1,0,0 then 0.
REQ-032 din_valid pulsed with 0x55 during SHIFT of 0x0F -> ignored; the 0x0F frame completes unchanged (1,1,1,1,0,0,0,0, parity 0).
REQ-033 Scoreboard for all frames -> feeding dout into a serial even-ones checker cleared at frame start gives "even" after every parity bit.
